uart_rx_deframer: RTL
=====================

// Module: uart_rx_deframer
// PURPOSE
//  UART receiver. Stage directly downstream of the handheld's 8N1 UART transmitter.
//  Consumes the serial tx line at 115200 baud from a 30 MHz clock and recovers each byte.
//  Delivers bytes over a valid/ready interface to the host-side capture logic or the test bench.
//  Flags framing errors and overrun.
// PARAMETERS
//  CLOCK_FREQ  30000000  system clock frequency, Hz
//  BAUD_RATE   115200    line rate, bits/s
//  OVERSAMPLE  16        samples per bit; DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated (=16)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  rx         in   1  serial line, idle high, asynchronous to clk
//  rx_data    out  8  received byte, LSB first on the line
//  rx_valid   out  1  rx_data holds an unconsumed byte
//  rx_ready   in   1  consumer accepts byte when rx_valid & rx_ready
//  frame_err  out  1  1-cycle pulse: stop bit sampled 0
//  overrun    out  1  1-cycle pulse: new byte completed while holding register full
//  parity_err out  1  1-cycle pulse: parity mismatch (tied 0 without UART_RX_PARITY_EN)
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0
//   - sync flops=1, state=IDLE
//   - reset mid-frame aborts the frame; no partial byte is delivered
//  Input: 2-flop synchroniser on rx. All decisions use the synchronised value rxs (+2 clk latency).
//  Tick: counter 0..DIV-1 produces one tick per DIV clocks; it restarts at 0 on entry to START.
//   Sample index s = 0..OVERSAMPLE-1 advances per tick.
//   Bit value = majority of samples 7, 8, 9 (registered at s=9).
//  FSM states:
//   - IDLE: rxs==0 -> START.
//   - START: at s=9, majority==1 -> IDLE (glitch, no flags); else s wraps at 15 -> DATA, bit=0.
//   - DATA: at s=9 shift majority into bit[n]; at s=15, n==7 -> STOP (or PARITY), else n+1.
//   - STOP: at s=9 decide.
//       majority==1 -> commit byte, go IDLE immediately (half-bit early, absorbs baud error).
//       majority==0 -> frame_err pulse, discard byte, go WAIT_HIGH.
//   - WAIT_HIGH: stay until rxs==1, then IDLE (break / stuck-low line never re-triggers).
//  Commit rules (cycle after stop decision):
//   - rx_valid==0: load rx_data, rx_valid<=1.
//   - rx_valid==1 & rx_ready==1 in the commit cycle: old byte consumed, new byte loaded, rx_valid stays 1, no overrun.
//   - rx_valid==1 & rx_ready==0: overrun pulse; old byte kept, new byte dropped.
//  Handshake:
//   - rx_valid falls the cycle after rx_valid & rx_ready unless a commit coincides.
//   - rx_data is stable while rx_valid=1.
//  Timing:
//   - Latency: rx_valid rises 2 sync + ~9.5 bit periods after the start edge on rx.
//   - Bit period = DIV*OVERSAMPLE = 256 clk vs transmitter 261 clk (1.9% tolerated).
//   - Back-to-back frames with 1 stop bit are received without loss.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - frame is 8E1; PARITY state follows DATA.
//   - even parity over the 8 data bits + parity bit must be 0.
//   - mismatch: parity_err pulse at stop decision, byte discarded (no commit, no overrun); framing still checked.
//  UART_RX_PARITY_EN undefined: 8N1 as above, parity_err constant 0, no PARITY state.
// TESTING
//  1. Idle line, then frame 0x66 at 261 clk/bit, rx_ready=0 -> rx_valid=1, rx_data=8'h66, no flags; held until rx_ready=1, then rx_valid=0 next cycle.
//  2. 38 back-to-back frames "flag{FpG4_has_F0Ss_t001cha1n_n0Wwwwww}", rx_ready=1 -> 38 handshakes, bytes in order, no errors.
//  3. rx low for 40 clk then high -> returns to IDLE, rx_valid never set, all flags 0.
//  4. Frame 0x41 with stop bit 0, line held low 1000 clk -> one frame_err pulse, no rx_valid, no retrigger until line high.
//  5. Two frames 0x31, 0x32 with rx_ready=0 -> one overrun pulse, rx_data=8'h31; a third frame with rx_ready=1 in its commit cycle -> no overrun, 8'h33 delivered.
//  6. rst_n low mid-byte of 0x55, release, send 0xAA -> only 0xAA delivered; all outputs 0 during reset.
//     With UART_RX_PARITY_EN: 0xAA with odd parity -> parity_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deframer
// Purpose  : 16x-oversampled 8N1 UART receiver with valid/ready byte output,
//            framing-error and overrun pulses. Define UART_RX_PARITY_EN for 8E1.
// Revision : 1.0
// ============================================================================
module uart_rx_deframer #(
  parameter int CLOCK_FREQ = 30000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] C_DIV_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] C_S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] C_S_A      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] C_S_B      = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] C_S_MID    = SW'(OVERSAMPLE / 2 + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_PARITY    = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;
`endif

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_tick_cnt;
  logic [SW-1:0]   r_s;
  logic            r_samp_a;
  logic            r_samp_b;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_commit;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid;
  logic            r_frame_err;
  logic            r_overrun;
  logic            r_parity_err;
  logic            r_busy;

  logic            w_rxs;
  logic            w_tick;
  logic            w_mid;
  logic            w_end;
  logic            w_maj;
  logic            w_par_ok;

  assign w_rxs  = r_sync2;
  assign w_tick = (r_tick_cnt == C_DIV_LAST);
  assign w_mid  = w_tick && (r_s == C_S_MID);
  assign w_end  = w_tick && (r_s == C_S_LAST);
  // The third sample is taken live so the decision lands on the same tick.
  assign w_maj  = (r_samp_a & r_samp_b) | (r_samp_a & w_rxs) | (r_samp_b & w_rxs);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  assign w_par_ok = ~(^{r_shift, r_par_bit});
`else
  assign w_par_ok = 1'b1;
`endif

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign parity_err = r_parity_err;
  assign busy       = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Held at zero in IDLE so the tick phase restarts on every start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_s        <= '0;
      r_samp_a   <= 1'b1;
      r_samp_b   <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_tick_cnt <= '0;
      r_s        <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_s        <= (r_s == C_S_LAST) ? '0 : r_s + 1'b1;
      if (r_s == C_S_A) r_samp_a <= w_rxs;
      if (r_s == C_S_B) r_samp_b <= w_rxs;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_bit        <= 3'd0;
      r_shift      <= 8'd0;
      r_commit     <= 1'b0;
      r_rx_data    <= 8'd0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
`endif
    end else begin
      r_commit     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;

      // A consumer taking the old byte in the commit cycle frees the slot.
      if (r_commit) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_mid && w_maj) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_end) begin
            r_state <= S_DATA;
            r_bit   <= 3'd0;
          end
        end
        S_DATA: begin
          if (w_mid) r_shift <= {w_maj, r_shift[7:1]};
          if (w_end) begin
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_mid) r_par_bit <= w_maj;
          if (w_end) r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          // Decide at mid-stop so the next start edge is never missed.
          if (w_mid) begin
            if (w_maj) begin
              if (w_par_ok) r_commit     <= 1'b1;
              else          r_parity_err <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err  <= 1'b1;
              r_parity_err <= ~w_par_ok;
              r_state      <= S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (w_rxs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
